// File: rtl/afifo_rd_ptr_empty.sv
// rtl/afifo_rd_ptr_empty.sv - async FIFO read pointer, write-pointer synchroniser and empty/almost-empty flags
module afifo_rd_ptr_empty #(
   parameter int ADDRSIZE      = 4,
   parameter int SYNC_STAGES   = 2,
   parameter int AEMPTY_THRESH = 2
) (
   input  logic                rclk,
   input  logic                rrst,
   input  logic                rden,
   input  logic [ADDRSIZE:0]   wptr_gray,
   output logic [ADDRSIZE-1:0] raddr,
   output logic [ADDRSIZE:0]   rptr_gray,
   output logic                rd_empty,
   output logic                rd_aempty,
   output logic [ADDRSIZE:0]   rd_count,
   output logic                rd_underflow
);

   localparam logic [ADDRSIZE:0] AEMPTY_TH = AEMPTY_THRESH[ADDRSIZE:0];

   logic [ADDRSIZE:0] sync_q [SYNC_STAGES];
   logic [ADDRSIZE:0] wq;
   logic [ADDRSIZE:0] wq_bin;

   logic [ADDRSIZE:0] rbin_q, rbin_d;
   logic [ADDRSIZE:0] rgray_q, rgray_d;
   logic [ADDRSIZE:0] count_q, count_d;
   logic              empty_q, empty_d;
   logic              aempty_q, aempty_d;
   logic              underflow_q, underflow_d;
   logic              rinc;

   // Plain flop chain: no logic between stages so every stage can resolve metastability.
   always_ff @(posedge rclk or posedge rrst) begin
      if (rrst) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= wptr_gray;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   assign wq = sync_q[SYNC_STAGES-1];

   always_comb begin
      wq_bin = '0;
      for (int i = 0; i <= ADDRSIZE; i++) wq_bin[i] = ^(wq >> i);
   end

   // Reads are gated by the registered empty flag, so no read past the last entry is accepted.
   assign rinc        = rden & ~empty_q;
   assign rbin_d      = rbin_q + {{ADDRSIZE{1'b0}}, rinc};
   assign rgray_d     = (rbin_d >> 1) ^ rbin_d;
   assign count_d     = wq_bin - rbin_d;
   assign empty_d     = (rgray_d == wq);
   assign aempty_d    = (count_d <= AEMPTY_TH);
   assign underflow_d = rden & empty_q;

   always_ff @(posedge rclk or posedge rrst) begin
      if (rrst) begin
         rbin_q      <= '0;
         rgray_q     <= '0;
         count_q     <= '0;
         empty_q     <= 1'b1;
         aempty_q    <= 1'b1;
         underflow_q <= 1'b0;
      end else begin
         rbin_q      <= rbin_d;
         rgray_q     <= rgray_d;
         count_q     <= count_d;
         empty_q     <= empty_d;
         aempty_q    <= aempty_d;
         underflow_q <= underflow_d;
      end
   end

   assign raddr        = rbin_q[ADDRSIZE-1:0];
   assign rptr_gray    = rgray_q;
   assign rd_empty     = empty_q;
   assign rd_aempty    = aempty_q;
   assign rd_count     = count_q;
   assign rd_underflow = underflow_q;

endmodule
